// File: rtl/fa_pkg.sv
// Shared sizing for the FIR -> frame buffer -> FFT chain.
// Pointer-width helper keeps single-sample frames legal.
package fa_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned FRAME_LEN   = 16;
  localparam int unsigned FRAME_CNT_W = 8;

  function automatic int unsigned ptr_w(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of sample storage.
// It has a single write port, and the whole bank is presented as a packed read vector.
module frame_bank #(
  parameter int unsigned SAMPLE_W  = fa_pkg::SAMPLE_W,
  parameter int unsigned FRAME_LEN = fa_pkg::FRAME_LEN,
  parameter int unsigned PTR_W     = fa_pkg::ptr_w(FRAME_LEN)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [PTR_W-1:0]              waddr,
  input  logic [SAMPLE_W-1:0]           wdata,
  output logic [SAMPLE_W*FRAME_LEN-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem_q [FRAME_LEN];

  // Storage is deliberately left out of reset; the full flags qualify it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < FRAME_LEN; i++) begin : g_rd
    assign rdata[i*SAMPLE_W +: SAMPLE_W] = mem_q[i];
  end

endmodule

// File: rtl/fir_frame_buf.sv
// Ping-pong frame buffer between the FIR output and the FFT input.
// Frames are always aligned to sample 0, and a sample is dropped when the write bank is still full.
module fir_frame_buf
  import fa_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = fa_pkg::SAMPLE_W,
  parameter int unsigned FRAME_LEN = fa_pkg::FRAME_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fir_valid,
  input  logic [SAMPLE_W-1:0]                fir_d,
  input  logic                               frame_ready,
  output logic                               frame_valid,
  output logic [SAMPLE_W*FRAME_LEN-1:0]      frame_data,
  output logic [fa_pkg::FRAME_CNT_W-1:0]     frame_cnt,
  output logic                               overflow
);

  localparam int unsigned PtrW = ptr_w(FRAME_LEN);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(FRAME_LEN - 1);

  logic [1:0]             full_q, full_d;
  logic                   wbank_q, wbank_d;
  logic                   rbank_q, rbank_d;
  logic [PtrW-1:0]        wptr_q, wptr_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overflow_q, overflow_d;

  logic accept, drop, last, handshake;
  logic [1:0] bank_we;
  logic [SAMPLE_W*FRAME_LEN-1:0] rdata0, rdata1;

  assign accept    = fir_valid & ~full_q[wbank_q];
  assign drop      = fir_valid &  full_q[wbank_q];
  assign last      = accept & (wptr_q == LastIdx);
  assign handshake = full_q[rbank_q] & frame_ready;

  assign bank_we[0] = ~rst & accept & ~wbank_q;
  assign bank_we[1] = ~rst & accept &  wbank_q;

  // Completion and release never hit the same bank: a full write bank never accepts.
  always_comb begin
    full_d      = full_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wptr_d      = wptr_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    if (handshake) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      frame_cnt_d     = frame_cnt_q + 1'b1;
    end
    if (last) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
      wptr_d          = '0;
    end else if (accept) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (drop) begin
      wptr_d     = '0;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wptr_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wptr_q      <= wptr_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  frame_bank #(
    .SAMPLE_W  (SAMPLE_W),
    .FRAME_LEN (FRAME_LEN),
    .PTR_W     (PtrW)
  ) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (wptr_q),
    .wdata (fir_d),
    .rdata (rdata0)
  );

  frame_bank #(
    .SAMPLE_W  (SAMPLE_W),
    .FRAME_LEN (FRAME_LEN),
    .PTR_W     (PtrW)
  ) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (wptr_q),
    .wdata (fir_d),
    .rdata (rdata1)
  );

  assign frame_valid = full_q[rbank_q];
  assign frame_data  = rbank_q ? rdata1 : rdata0;
  assign frame_cnt   = frame_cnt_q;
  assign overflow    = overflow_q;

endmodule
